// File: rtl/timeout_pkg.sv
// Shared types and constants for the multi-channel timeout timer.
// The channel FSM states and the per-channel mode encodings live here,
// so the top and the channel sub-module agree on a single definition.
package timeout_pkg;

  // Per-channel life cycle: waiting for start, counting, or finished (one-shot)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ch_state_e;

  // Mode encodings as sampled from mode_i together with start_i
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // A programmed limit of zero behaves exactly like a limit of one tick
  function automatic logic [31:0] effective_limit(input logic [31:0] lim);
    return (lim == 32'd0) ? 32'd1 : lim;
  endfunction

endpackage

// File: rtl/timeout_channel.sv
// One independent timeout channel: IDLE/RUN/DONE state machine, tick
// counter, latched limit and mode, one-cycle timeout pulse and sticky
// expired flag. Counting only advances on cycles where tick_i is high.
module timeout_channel
  import timeout_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] limit_i,
  input  logic             clear_i,
  output logic             busy_o,
  output logic             timeout_o,
  output logic             expired_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic             mode_q, mode_d;
  logic             timeout_q, timeout_d;
  logic             expired_q, expired_d;
  logic [CNT_W-1:0] lim_eff;
  logic             expire;

  // The raw limit is kept so that reset leaves it at zero; zero maps to one here
  assign lim_eff = CNT_W'(effective_limit(32'(lim_q)));

  // Expiry happens on the tick that would otherwise move the counter to the limit
  assign expire = (state_q == RUN) && tick_i && (cnt_q == (lim_eff - CNT_ONE));

  // State register plus counter, latches and output flags, all reset to zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lim_q     <= '0;
      mode_q    <= MODE_ONESHOT;
      timeout_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lim_q     <= lim_d;
      mode_q    <= mode_d;
      timeout_q <= timeout_d;
      expired_q <= expired_d;
    end
  end

  // Next-state logic: stop in RUN aborts silently, otherwise count/expire and then
  // let a start (blocked by any concurrent stop) override the state and counter
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lim_d     = lim_q;
    mode_d    = mode_q;
    timeout_d = 1'b0;
    expired_d = expired_q & ~clear_i;

    if ((state_q == RUN) && stop_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      if ((state_q == RUN) && tick_i) begin
        if (expire) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          expired_d = 1'b1;
          state_d   = (mode_q == MODE_PERIODIC) ? RUN : DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      if (start_i && !stop_i) begin
        state_d = RUN;
        cnt_d   = '0;
        lim_d   = limit_i;
        mode_d  = mode_i;
      end
    end
  end

  assign busy_o    = (state_q == RUN);
  assign timeout_o = timeout_q;
  assign expired_o = expired_q;

endmodule

// File: rtl/multi_timeout_timer.sv
// Multi-channel timeout timer top: NUM_CH independent timeout_channel
// instances fed by one shared count tick.
// Optional feature macro TIMEOUT_PRESCALE_EN: when defined, a shared
// prescaler divides the clock by PRESCALE to form the tick; when undefined
// every clock cycle is a tick and no prescaler exists.
module multi_timeout_timer
  import timeout_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
`ifdef TIMEOUT_PRESCALE_EN
  , parameter int PRESCALE = 100
`endif
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_CH-1:0]       start_i,
  input  logic [NUM_CH-1:0]       stop_i,
  input  logic [NUM_CH-1:0]       mode_i,
  input  logic [NUM_CH*CNT_W-1:0] limit_i,
  input  logic [NUM_CH-1:0]       clear_i,
  output logic [NUM_CH-1:0]       busy_o,
  output logic [NUM_CH-1:0]       timeout_o,
  output logic [NUM_CH-1:0]       expired_o
);

  logic tick;

`ifdef TIMEOUT_PRESCALE_EN
  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;
  logic          any_busy;

  assign any_busy = |busy_o;

  // Shared prescaler: free-runs 0..PRESCALE-1 while any channel counts, parks at 0 otherwise
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q <= '0;
    end else if (!any_busy) begin
      pre_q <= '0;
    end else if (pre_q == PRE_LAST) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

  assign tick = any_busy && (pre_q == PRE_LAST);
`else
  assign tick = 1'b1;
`endif

  // One channel per bit; channels share only the tick and never interact
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    timeout_channel #(
      .CNT_W (CNT_W)
    ) u_channel (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .tick_i    (tick),
      .start_i   (start_i[c]),
      .stop_i    (stop_i[c]),
      .mode_i    (mode_i[c]),
      .limit_i   (limit_i[c*CNT_W +: CNT_W]),
      .clear_i   (clear_i[c]),
      .busy_o    (busy_o[c]),
      .timeout_o (timeout_o[c]),
      .expired_o (expired_o[c])
    );
  end

endmodule

// File: doc/multi_timeout_timer.md
MULTI_TIMEOUT_TIMER -- requirements
Module: multi_timeout_timer

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent timeout channels, 1..16.
REQ-002 Parameter CNT_W, default 32: counter and limit width per channel, 8..32.
REQ-003 Parameter PRESCALE, default 100: clock cycles per count tick; present only under TIMEOUT_PRESCALE_EN, 2..65535.
REQ-004 clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 start_i  input  NUM_CH  per-channel start/restart request, level-sampled each cycle.
REQ-007 stop_i  input  NUM_CH  per-channel abort request.
REQ-008 mode_i  input  NUM_CH  per-channel mode, sampled with start: 0 = one-shot, 1 = periodic.
REQ-009 limit_i  input  NUM_CH*CNT_W  per-channel timeout length in ticks; channel c occupies bits [c*CNT_W +: CNT_W]; sampled with start.
REQ-010 clear_i  input  NUM_CH  per-channel clear of the sticky expired flag.
REQ-011 busy_o  output  NUM_CH  channel is in RUN.
REQ-012 timeout_o  output  NUM_CH  one-cycle registered pulse per expiry.
REQ-013 expired_o  output  NUM_CH  sticky expiry flag.

Function
REQ-014 Each channel SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-015 start_i in any state SHALL latch limit_i and mode_i, zero the counter and enter RUN at that edge (edge 0); start_i in RUN restarts the channel.
REQ-016 In RUN, the counter SHALL increment by 1 on every tick; a tick is every clock cycle without the macro.
REQ-017 At a tick where counter == latched limit - 1, the channel SHALL zero the counter, pulse timeout_o for one cycle (visible from edge L for limit L, no prescale), and set expired_o.
REQ-018 After expiry, a one-shot channel SHALL enter DONE; a periodic channel SHALL remain in RUN and expire every L ticks.
REQ-019 A latched limit of 0 SHALL be treated as 1.
REQ-020 Counter arithmetic SHALL be unsigned CNT_W-bit; the counter never wraps, because it resets at limit - 1.
REQ-021 stop_i in RUN SHALL force IDLE with the counter zeroed and SHALL produce no timeout_o pulse that cycle; stop_i in IDLE or DONE has no effect.
REQ-022 When start_i and stop_i are asserted in the same cycle, stop_i SHALL win.
REQ-023 When start_i coincides with an expiry tick, the timeout_o pulse and expired_o set SHALL still occur, and the restart SHALL take effect.
REQ-024 clear_i SHALL clear expired_o at the next edge; if clear_i coincides with a new expiry, the set SHALL win.
REQ-025 Channels SHALL be fully independent; no ordering or arbitration exists between channels.

Reset
REQ-026 While rst_ni is low: all channels in IDLE, counters 0, busy_o = 0, timeout_o = 0, expired_o = 0, latched limit/mode = 0, prescaler = 0.
REQ-027 Reset asserted mid-count SHALL abort the count immediately with no timeout_o pulse; after deassertion a channel stays IDLE until start_i.

Configuration
REQ-028 With TIMEOUT_PRESCALE_EN defined, a single shared prescaler SHALL count 0..PRESCALE-1 and generate a one-cycle tick at PRESCALE-1; the prescaler runs whenever at least one channel is busy and resets to 0 when none is busy.
REQ-029 Without TIMEOUT_PRESCALE_EN, the PRESCALE parameter and prescaler logic SHALL be absent, and tick SHALL be constant 1.

Structure
REQ-030 Package timeout_pkg SHALL hold the channel state enum (IDLE/RUN/DONE) and the mode constants (MODE_ONESHOT = 0, MODE_PERIODIC = 1).
REQ-031 Sub-module timeout_channel SHALL implement one channel (FSM, counter, latches, flags); the top SHALL hold the prescaler and NUM_CH generated instances.

Verification
REQ-032 One-shot: NUM_CH=4, no prescale, ch0 start with limit=5 -> timeout_o[0] high only in the 5th cycle after start, expired_o[0]=1, busy_o[0]=0 afterwards.
REQ-033 Periodic: ch1 limit=3, mode=1 -> timeout_o[1] pulses every 3 cycles across 4 periods; busy_o[1] stays 1 until stop_i[1], then no further pulses.
REQ-034 Collisions: start and stop in the same cycle -> channel stays IDLE; clear_i at an expiry cycle -> expired_o remains 1; start at an expiry cycle -> pulse seen, next expiry L cycles later.
REQ-035 Reset: rst_ni low at count 3 of limit 10 -> all outputs 0 asynchronously; no pulse after release.
REQ-036 Prescale (TIMEOUT_PRESCALE_EN, PRESCALE=4): limit=2 -> timeout_o asserted about 8 cycles after start; limit=0 -> expiry after one tick.
